pc_predict_update: RTL and testbench

- Parametrised next-generation PC update unit for the pipelined Y86-64 core; replaces the single-cycle SEQ PC update in the fetch stage.
- Holds the fetch PC and predicts the next PC each cycle: jmp, call and jXX are predicted taken; ret is predicted from a return-address stack (RAS).
- Accepts stall, mispredict and ret-redirect corrections from later stages.
- Freezes on any non-AOK status.

---
 rtl/pc_predict_update.sv | 157 +++++++++++++++
 tb/tb_pc_predict_update.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_update.sv
// rtl/pc_predict_update.sv - fetch PC register with next-PC prediction and return-address stack
module pc_predict_update #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         f_valid,
  input  logic [3:0]                   f_icode,
  input  logic [ADDR_W-1:0]            f_valC,
  input  logic [ADDR_W-1:0]            f_valP,
  input  logic                         stall,
  input  logic                         mispredict,
  input  logic [ADDR_W-1:0]            mis_target,
  input  logic                         ret_redirect,
  input  logic [ADDR_W-1:0]            ret_target,
  input  logic [1:0]                   status,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pred_pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ret_wait,
  output logic                         halted
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               push, pop;
  logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0]  ras_top;

  // The pointer addresses the next free slot, so the top lives one below it (wrapping).
  assign ras_top = ras_q[ptr_q - PTR_W'(1)];

  // Zero-latency prediction: taken for jXX/call, RAS top for ret when the stack holds something.
  always_comb begin
    pred_pc = f_valP;
    if (f_icode == I_JXX || f_icode == I_CALL) begin
      pred_pc = f_valC;
    end else if (f_icode == I_RET && count_q != '0) begin
      pred_pc = ras_top;
    end
  end

  // Next-state selection: corrections from later stages outrank the fetch-side prediction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      RUN: begin
        if (status != 2'd0) begin
          state_d = HALT;
        end else if (mispredict) begin
          pc_d = mis_target;
        end else if (ret_redirect) begin
          pc_d = ret_target;
        end else if (!stall && f_valid) begin
          pc_d = pred_pc;
          if (f_icode == I_CALL) begin
            push = 1'b1;
          end else if (f_icode == I_RET) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              // Nothing to predict from: park until writeback resolves the target.
              pc_d    = pc_q;
              state_d = RET_WAIT;
            end
          end
        end
      end
      RET_WAIT: begin
        if (status != 2'd0) begin
          state_d = HALT;
        end else if (mispredict) begin
          pc_d    = mis_target;
          state_d = RUN;
        end else if (ret_redirect) begin
          pc_d    = ret_target;
          state_d = RUN;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Stack bookkeeping: a push while full overwrites the oldest slot and flags it stickily.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control and PC registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Stack storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[ptr_q] <= f_valP;
    end
  end

  assign pc           = pc_q;
  assign ras_count    = count_q;
  assign ras_overflow = ovf_q;
  assign ret_wait     = (state_q == RET_WAIT);
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_pc_predict_update.sv
// tb/tb_pc_predict_update.sv - directed self-checking bench for pc_predict_update
module tb_pc_predict_update;

  localparam int ADDR_W = 64;

  logic              clk;
  logic              rst_n;
  logic              f_valid;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic              stall;
  logic              mispredict;
  logic [ADDR_W-1:0] mis_target;
  logic              ret_redirect;
  logic [ADDR_W-1:0] ret_target;
  logic [1:0]        status;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pred_pc;
  logic [3:0]        ras_count;
  logic              ras_overflow;
  logic              ret_wait;
  logic              halted;

  int total;
  int bad;

  pc_predict_update #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(8),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_valid     (f_valid),
    .f_icode     (f_icode),
    .f_valC      (f_valC),
    .f_valP      (f_valP),
    .stall       (stall),
    .mispredict  (mispredict),
    .mis_target  (mis_target),
    .ret_redirect(ret_redirect),
    .ret_target  (ret_target),
    .status      (status),
    .pc          (pc),
    .pred_pc     (pred_pc),
    .ras_count   (ras_count),
    .ras_overflow(ras_overflow),
    .ret_wait    (ret_wait),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp);
    f_valid = 1'b1;
    f_icode = icode;
    f_valC  = valc;
    f_valP  = valp;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    f_valid = 1'b0; f_icode = 4'h0; f_valC = '0; f_valP = '0;
    stall = 1'b0; mispredict = 1'b0; mis_target = '0;
    ret_redirect = 1'b0; ret_target = '0; status = 2'd0;

    #2;
    check("reset_pc", pc, 64'h0);
    check("reset_cnt", ras_count, 0);
    check("reset_halted", halted, 0);
    check("reset_retwait", ret_wait, 0);
    check("reset_ovf", ras_overflow, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // straight-line
    set_f(4'h6, 64'h0, 64'h2);
    #1;
    check("pred_seq", pred_pc, 64'h2);
    for (int i = 1; i <= 3; i++) begin
      f_valP = 64'(2 * i);
      step();
      check("seq_pc", pc, 64'(2 * i));
    end
    stall  = 1'b1;
    f_valP = 64'h8;
    step();
    check("stall1_pc", pc, 64'h6);
    step();
    check("stall2_pc", pc, 64'h6);
    stall = 1'b0;
    step();
    check("after_stall_pc", pc, 64'h8);

    // call / ret
    set_f(4'h7, 64'h10, 64'hA);
    step();
    check("jmp_pc", pc, 64'h10);
    set_f(4'h8, 64'h100, 64'h19);
    #1;
    check("pred_call", pred_pc, 64'h100);
    step();
    check("call_pc", pc, 64'h100);
    check("call_cnt", ras_count, 1);
    set_f(4'h9, 64'h0, 64'h101);
    #1;
    check("pred_ret", pred_pc, 64'h19);
    step();
    check("ret_pc", pc, 64'h19);
    check("ret_cnt", ras_count, 0);

    // overflow
    for (int i = 1; i <= 9; i++) begin
      set_f(4'h8, 64'h200 + 64'(i * 16), 64'(i));
      step();
    end
    check("ovf_pc", pc, 64'h290);
    check("ovf_cnt", ras_count, 8);
    check("ovf_flag", ras_overflow, 1);
    for (int i = 9; i >= 2; i--) begin
      set_f(4'h9, 64'h0, 64'hDEAD);
      step();
      check("ovf_ret_pc", pc, 64'(i));
    end
    check("ovf_drain_cnt", ras_count, 0);
    check("ovf_sticky", ras_overflow, 1);
    set_f(4'h9, 64'h0, 64'hDEAD);
    #1;
    check("pred_ret_empty", pred_pc, 64'hDEAD);
    step();
    check("retwait_flag", ret_wait, 1);
    check("retwait_pc", pc, 64'h2);
    set_f(4'h8, 64'h300, 64'h77);
    step();
    check("retwait_ignore_pc", pc, 64'h2);
    check("retwait_ignore_cnt", ras_count, 0);
    ret_redirect = 1'b1;
    ret_target   = 64'h1;
    f_valid      = 1'b0;
    step();
    ret_redirect = 1'b0;
    check("redirect_pc", pc, 64'h1);
    check("redirect_run", ret_wait, 0);

    // branch mispredict beats stall
    set_f(4'h7, 64'h80, 64'h29);
    step();
    check("br_pc", pc, 64'h80);
    mispredict = 1'b1;
    mis_target = 64'h29;
    stall      = 1'b1;
    step();
    mispredict = 1'b0;
    stall      = 1'b0;
    check("mis_pc", pc, 64'h29);

    // halt
    set_f(4'h8, 64'h40, 64'h2E);
    step();
    check("pre_halt_pc", pc, 64'h40);
    check("pre_halt_cnt", ras_count, 1);
    status     = 2'd2;
    mispredict = 1'b1;
    mis_target = 64'h999;
    step();
    check("halt_flag", halted, 1);
    check("halt_pc", pc, 64'h40);
    status       = 2'd0;
    ret_redirect = 1'b1;
    ret_target   = 64'h555;
    step();
    mispredict   = 1'b0;
    ret_redirect = 1'b0;
    set_f(4'h8, 64'h600, 64'h44);
    step();
    step();
    check("halt_frozen_pc", pc, 64'h40);
    check("halt_frozen_cnt", ras_count, 1);
    check("halt_still", halted, 1);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 64'h0);
    check("async_rst_halted", halted, 0);
    check("async_rst_cnt", ras_count, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    set_f(4'h6, 64'h0, 64'h2);
    step();
    check("post_rst_pc", pc, 64'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
